// File: rtl/fp_mult_arbiter.sv
// Purpose : shares one pipelined fp_mult between two requesters; issues operands, tags them, returns products.
// Latency : accept edge t0 -> res_valid from edge t0+LATENCY+1 (LATENCY+1 cycles).
// Backpressure: one outstanding op per requester; result held until res_ack; round-robin on contention.
//
// Ports:
//   clk, rst                       single clock, synchronous active-high reset
//   req_valid*/req_ready*          operand channel per requester (valid/ready)
//   req_a*, req_b*                 IEEE-754 single operands
//   res_valid*/res_y*/res_ack*     held result channel per requester
//   mult_a, mult_b, mult_y         connection to the external fp_mult instance
module fp_mult_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid0,
    output logic        req_ready0,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,

    input  logic        req_valid1,
    output logic        req_ready1,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,

    output logic        res_valid0,
    output logic [31:0] res_y0,
    input  logic        res_ack0,

    output logic        res_valid1,
    output logic [31:0] res_y1,
    input  logic        res_ack1,

    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    input  logic [31:0] mult_y
);

    // One tag per multiplier pipeline slot: was an op issued, and for whom.
    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

    // ------------------------------------------------------------------
    // Requester-indexed views of the flat ports
    // ------------------------------------------------------------------
    logic [1:0]        req_vld;
    logic [1:0]        res_ack;
    logic [1:0][31:0]  req_a;
    logic [1:0][31:0]  req_b;

    assign req_vld = {req_valid1, req_valid0};
    assign res_ack = {res_ack1, res_ack0};
    assign req_a   = {req_a1, req_a0};
    assign req_b   = {req_b1, req_b0};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            busy_q,    busy_d;
    logic [1:0]            res_vld_q, res_vld_d;
    logic [1:0][31:0]      res_y_q,   res_y_d;
    logic [31:0]           mult_a_q,  mult_a_d;
    logic [31:0]           mult_b_q,  mult_b_d;
    logic                  turn_q,    turn_d;
    tag_t [LATENCY:0]      tag_q,     tag_d;

    // ------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------
    logic [1:0] elig;
    logic [1:0] rdy;
    logic [1:0] acc;
    logic       any_acc;
    logic       win_id;
    logic       cap_vld;
    logic       cap_id;

    always_comb begin
        // Eligibility looks only at registered busy, so an ack edge frees the
        // requester for the following cycle, never the same one.
        elig = ~busy_q;

        // A requester yields only when the other one is eligible, valid and
        // holds the turn; the two terms cannot both be true, so at most one
        // accept happens per cycle.
        rdy[0] = !rst && elig[0] && (!req_vld[1] || !elig[1] || (turn_q == 1'b0));
        rdy[1] = !rst && elig[1] && (!req_vld[0] || !elig[0] || (turn_q == 1'b1));

        acc     = rdy & req_vld;
        any_acc = |acc;
        win_id  = acc[1];

        cap_vld = tag_q[LATENCY].vld;
        cap_id  = tag_q[LATENCY].id;
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        busy_d    = busy_q;
        res_vld_d = res_vld_q;
        res_y_d   = res_y_q;
        mult_a_d  = mult_a_q;
        mult_b_d  = mult_b_q;
        turn_d    = turn_q;
        tag_d     = tag_q;

        for (int i = 0; i < 2; i++) begin
            // An ack with no result pending is ignored.
            if (res_ack[i] && res_vld_q[i]) begin
                busy_d[i]    = 1'b0;
                res_vld_d[i] = 1'b0;
            end
            // Accept needs !busy and a pending result implies busy, so this
            // never collides with the ack branch above.
            if (acc[i]) begin
                busy_d[i] = 1'b1;
            end
            // The tag leaving the last stage lines up with the product on
            // mult_y; the owner is still busy, so its slot is free.
            if (cap_vld && (cap_id == i[0])) begin
                res_vld_d[i] = 1'b1;
                res_y_d[i]   = mult_y;
            end
        end

        // Operands hold between issues; the multiplier output for idle slots
        // is simply never captured because its tag is invalid.
        if (any_acc) begin
            mult_a_d = req_a[win_id];
            mult_b_d = req_b[win_id];
            turn_d   = ~win_id;
        end

        // Free-running tag shift, one stage per multiplier cycle plus the
        // operand register in front of it.
        tag_d[0].vld = any_acc;
        tag_d[0].id  = win_id;
        for (int k = 1; k <= LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            res_vld_q <= '0;
            res_y_q   <= '0;
            mult_a_q  <= '0;
            mult_b_q  <= '0;
            turn_q    <= 1'b0;
            tag_q     <= '0;
        end else begin
            busy_q    <= busy_d;
            res_vld_q <= res_vld_d;
            res_y_q   <= res_y_d;
            mult_a_q  <= mult_a_d;
            mult_b_q  <= mult_b_d;
            turn_q    <= turn_d;
            tag_q     <= tag_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready0 = rdy[0];
    assign req_ready1 = rdy[1];
    assign res_valid0 = res_vld_q[0];
    assign res_valid1 = res_vld_q[1];
    assign res_y0     = res_y_q[0];
    assign res_y1     = res_y_q[1];
    assign mult_a     = mult_a_q;
    assign mult_b     = mult_b_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Purpose : directed bench for fp_mult_arbiter with a table-driven stand-in for fp_mult.
// Latency : stand-in multiplier is LAT register stages, matching the arbiter's LATENCY.
// Backpressure: requesters driven directly; optional auto-ack per requester.
module tb_fp_mult_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid0, req_valid1;
    logic        req_ready0, req_ready1;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic        res_valid0, res_valid1;
    logic [31:0] res_y0, res_y1;
    logic        res_ack0, res_ack1;
    logic [31:0] mult_a, mult_b, mult_y;

    logic        man_ack0, man_ack1;
    logic        auto_ack0, auto_ack1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [31:0] exp_y0, exp_y1;

    int acc_id  [$];
    int acc_cyc [$];

    always #5 clk = ~clk;

    assign res_ack0 = man_ack0 | (auto_ack0 & res_valid0);
    assign res_ack1 = man_ack1 | (auto_ack1 & res_valid1);

    fp_mult_arbiter #(.LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid0 (req_valid0),
        .req_ready0 (req_ready0),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_valid1 (req_valid1),
        .req_ready1 (req_ready1),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .res_valid0 (res_valid0),
        .res_y0     (res_y0),
        .res_ack0   (res_ack0),
        .res_valid1 (res_valid1),
        .res_y1     (res_y1),
        .res_ack1   (res_ack1),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_y     (mult_y)
    );

    // Stand-in fp_mult: hand-computed products for the operand pairs used here.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ab;
        ab = {a, b};
        case (ab)
            {32'h3FC00000, 32'h40000000}: return 32'h40400000; // 1.5*2.0 = 3.0
            {32'h40000000, 32'h40400000}: return 32'h40C00000; // 2.0*3.0 = 6.0
            {32'h3F000000, 32'h40000000}: return 32'h3F800000; // 0.5*2.0 = 1.0
            default:                      return 32'h7FC00000;
        endcase
    endfunction

    logic [31:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= fmul(mult_a, mult_b);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mult_y = mpipe[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Accept monitor and result-consumption checker, sampled mid-cycle.
    always @(negedge clk) begin
        if (req_valid0 && req_ready0) begin acc_id.push_back(0); acc_cyc.push_back(cyc); end
        if (req_valid1 && req_ready1) begin acc_id.push_back(1); acc_cyc.push_back(cyc); end
        if (res_valid0 && res_ack0) chk_eq("consume_y0", res_y0, exp_y0);
        if (res_valid1 && res_ack1) chk_eq("consume_y1", res_y1, exp_y1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid0 = 0; req_valid1 = 0; man_ack0 = 0; man_ack1 = 0;
        tick();
        tick();
        chk_eq("rst_ready", {30'd0, req_ready1, req_ready0}, 32'd0);
        chk_eq("rst_valid", {30'd0, res_valid1, res_valid0}, 32'd0);
        chk_eq("rst_y0", res_y0, 32'd0);
        chk_eq("rst_y1", res_y1, 32'd0);
        chk_eq("rst_ma", mult_a, 32'd0);
        chk_eq("rst_mb", mult_b, 32'd0);
        rst = 1'b0;
    endtask

    // Requester 0 alone: accept, wait LAT+1, check held result, ack.
    task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic [31:0] y);
        exp_y0 = y;
        req_a0 = a; req_b0 = b; req_valid0 = 1'b1;
        #1;
        chk_eq("single_ready", {31'd0, req_ready0}, 32'd1);
        tick();
        req_valid0 = 1'b0;
        chk_eq("single_ma", mult_a, a);
        chk_eq("single_mb", mult_b, b);
        for (int k = 1; k <= LAT; k++) begin
            tick();
            chk_eq("single_early", {31'd0, res_valid0}, 32'd0);
        end
        tick();
        chk_eq("single_valid", {31'd0, res_valid0}, 32'd1);
        chk_eq("single_y", res_y0, y);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_eq("single_hold_v", {31'd0, res_valid0}, 32'd1);
            chk_eq("single_hold_y", res_y0, y);
        end
        man_ack0 = 1'b1;
        tick();
        man_ack0 = 1'b0;
        chk_eq("single_clear", {31'd0, res_valid0}, 32'd0);
        chk_eq("single_reready", {31'd0, req_ready0}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid0 = 0; req_valid1 = 0;
        req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
        man_ack0 = 0; man_ack1 = 0; auto_ack0 = 0; auto_ack1 = 0;
        exp_y0 = 0; exp_y1 = 0;

        // Single op
        do_reset();
        run_single(32'h3FC00000, 32'h40000000, 32'h40400000);

        // Spurious ack while idle
        man_ack0 = 1'b1;
        tick();
        man_ack0 = 1'b0;
        chk_eq("spur_valid", {31'd0, res_valid0}, 32'd0);
        chk_eq("spur_y", res_y0, 32'h40400000);
        chk_eq("spur_ready", {31'd0, req_ready0}, 32'd1);
        run_single(32'h3F000000, 32'h40000000, 32'h3F800000);

        // Contention
        do_reset();
        exp_y0 = 32'h40C00000; exp_y1 = 32'h40400000;
        req_a0 = 32'h40000000; req_b0 = 32'h40400000;
        req_a1 = 32'h3FC00000; req_b1 = 32'h40000000;
        req_valid0 = 1; req_valid1 = 1;
        #1;
        chk_eq("cont_ready0", {31'd0, req_ready0}, 32'd1);
        chk_eq("cont_ready1", {31'd0, req_ready1}, 32'd0);
        tick();
        req_valid0 = 0;
        chk_eq("cont_ready1b", {31'd0, req_ready1}, 32'd1);
        tick();
        req_valid1 = 0;
        tick();
        chk_eq("cont_none", {30'd0, res_valid1, res_valid0}, 32'd0);
        tick();
        chk_eq("cont_first", {30'd0, res_valid1, res_valid0}, 32'd1);
        chk_eq("cont_y0", res_y0, 32'h40C00000);
        tick();
        chk_eq("cont_both", {30'd0, res_valid1, res_valid0}, 32'd3);
        chk_eq("cont_y1", res_y1, 32'h40400000);
        man_ack0 = 1; man_ack1 = 1;
        tick();
        man_ack0 = 0; man_ack1 = 0;
        chk_eq("cont_clear", {30'd0, res_valid1, res_valid0}, 32'd0);

        // Fairness: 20 ops, both valid, immediate acks
        do_reset();
        auto_ack0 = 1; auto_ack1 = 1;
        acc_id.delete(); acc_cyc.delete();
        req_valid0 = 1; req_valid1 = 1;
        for (int t = 0; t < 200 && acc_id.size() < 20; t++) tick();
        req_valid0 = 0; req_valid1 = 0;
        chk_eq("fair_count", {31'd0, acc_id.size() >= 20}, 32'd1);
        if (acc_id.size() >= 20) begin
            chk_eq("fair_first", acc_id[0], 32'd0);
            for (int k = 1; k < 20; k++) begin
                chk_eq("fair_alt", acc_id[k], 32'(1 - acc_id[k-1]));
                chk_eq("fair_gap", acc_cyc[k] - acc_cyc[k-1], (k % 2) ? 32'd1 : 32'd4);
            end
        end
        for (int t = 0; t < 10; t++) tick();
        auto_ack0 = 0; auto_ack1 = 0;

        // Result hold: requester 1 sits on its result, requester 0 keeps issuing
        acc_id.delete(); acc_cyc.delete();
        auto_ack0 = 1;
        req_valid1 = 1;
        #1;
        chk_eq("hold_ready1", {31'd0, req_ready1}, 32'd1);
        tick();
        req_valid1 = 0;
        req_valid0 = 1;
        begin
            int t;
            t = 0;
            while (!res_valid1 && t < 10) begin tick(); t++; end
        end
        chk_eq("hold_arrive", {31'd0, res_valid1}, 32'd1);
        req_valid1 = 1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk_eq("hold_y1", res_y1, 32'h40400000);
            chk_eq("hold_v1", {31'd0, res_valid1}, 32'd1);
            chk_eq("hold_rdy1", {31'd0, req_ready1}, 32'd0);
            tick();
        end
        req_valid1 = 0;
        man_ack1 = 1;
        tick();
        man_ack1 = 0;
        chk_eq("hold_clear", {31'd0, res_valid1}, 32'd0);
        req_valid0 = 0;
        for (int t = 0; t < 8; t++) tick();
        auto_ack0 = 0;
        begin
            int n0, last0;
            n0 = 0; last0 = -1;
            for (int k = 0; k < acc_id.size(); k++) begin
                if (acc_id[k] == 0) begin
                    if (last0 >= 0) chk_eq("hold_tput0", acc_cyc[k] - last0, LAT + 3);
                    last0 = acc_cyc[k];
                    n0++;
                end
            end
            chk_eq("hold_n0", {31'd0, n0 >= 3}, 32'd1);
        end

        // Reset one cycle after an accept
        req_a0 = 32'h3FC00000; req_b0 = 32'h40000000;
        req_valid0 = 1;
        #1;
        chk_eq("mid_ready", {31'd0, req_ready0}, 32'd1);
        tick();
        req_valid0 = 0;
        rst = 1;
        #1;
        chk_eq("mid_rdy_in_rst", {30'd0, req_ready1, req_ready0}, 32'd0);
        tick();
        chk_eq("mid_valid", {30'd0, res_valid1, res_valid0}, 32'd0);
        chk_eq("mid_y0", res_y0, 32'd0);
        chk_eq("mid_y1", res_y1, 32'd0);
        chk_eq("mid_ma", mult_a, 32'd0);
        chk_eq("mid_mb", mult_b, 32'd0);
        rst = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            chk_eq("mid_no_result", {30'd0, res_valid1, res_valid0}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_mult_arbiter.md
# fp_mult_arbiter

Shares one pipelined `fp_mult` single-precision multiplier between two requesters. Each requester has a valid/ready operand channel and a held result channel. The block registers the operands and tracks each issued operation through the multiplier latency with a tag pipeline. It returns each product to its owner and holds it until acknowledged. It sits between the lab's operand sources and the `fp_mult` instance; `mult_a`/`mult_b`/`mult_y` connect directly to that instance's `a`/`b`/`y`.

## Interface
- `LATENCY`, 2: cycles from the first cycle operands are present on `mult_a`/`mult_b` to the first cycle the matching product is valid on `mult_y`. Range 1 or greater. `fp_mult` accepts new operands every cycle.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid0`, `req_valid1` input 1: requester i presents operands.
- `req_ready0`, `req_ready1` output 1: requester i's operands are accepted this cycle if valid.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` input 32: IEEE-754 single operands.
- `res_valid0`, `res_valid1` output 1: product for requester i is held on `res_y`i.
- `res_y0`, `res_y1` output 32: product bits, passed from `mult_y` unmodified.
- `res_ack0`, `res_ack1` input 1: requester i consumes its result.
- `mult_a`, `mult_b` output 32: registered operands to `fp_mult`.
- `mult_y` input 32: `fp_mult` output.

## Operation
- Per-requester state `busy_i`: set on accept; cleared when the result is acknowledged.
- `busy_i` covers both the in-flight period and the result-pending period, so at most one operation is outstanding per requester.
- **Eligibility:** requester i is eligible when `!busy_i`. Eligibility is computed from registered state only.
- **Grant:**
  - `req_ready_i = eligible_i && (!req_valid_j || !eligible_j || turn == i)`, where j is the other requester.
  - `turn` is a 1-bit round-robin pointer. It reset to 0. On every accept it becomes the other requester's index.
- **Mutual exclusion:** at most one accept per cycle; `req_ready0 && req_ready1 && req_valid0 && req_valid1` never occurs.
- **Issue:** on the accept edge, `mult_a`/`mult_b` load the winner's operands. Otherwise they hold their previous values.
- **Tag pipeline:**
  - LATENCY+1 stages, each holding {valid, id}.
  - Stage 0 loads {accept, winner id} on every edge; the pipe shifts every cycle with no stalls.
  - When the last stage is valid, `res_y`id captures `mult_y` and `res_valid`id sets on that edge.
- **Result hold:** `res_y`i and `res_valid`i are stable until the first edge where `res_ack`i is high.
  - That edge clears `res_valid`i and `busy_i`.
  - `res_ack`i while `res_valid`i is low is ignored.
- **Back-to-back:** the earliest new accept for requester i is the cycle after its ack edge. This is because ready depends on registered `busy_i`.
- **Reset:** `rst` high at an edge clears `busy`, all tag stages, `res_valid`, `res_y` (to 0), `mult_a`/`mult_b` (to 0) and `turn` (to 0).
  - Operations in flight in `fp_mult` at reset are discarded. Their products are never delivered.
  - While `rst` is high, `req_ready` is low.
- No arithmetic is performed in this block; widths pass through unchanged.

## Timing
- Accept at edge t0 → `mult_a`/`mult_b` valid from t0 → `mult_y` valid from edge t0+LATENCY → captured at edge t0+LATENCY+1.
- `res_valid`i is high from edge t0+LATENCY+1; total latency is LATENCY+1 cycles.
- Two requesters, both idle, both valid continuously: accepts alternate 0,1 on consecutive cycles starting with requester 0 after reset. Each then waits for its own result and ack.
- A single requester with immediate ack is accepted every LATENCY+3 cycles: accept, LATENCY+1 wait, ack edge, re-ready.
- Reset output values: `req_ready*` = 0 during reset, `res_valid*` = 0, `res_y*` = 0, `mult_a`/`mult_b` = 0.

## Test plan
- **Single op:** reset, then `req_valid0` with a=0x3FC00000 (1.5), b=0x40000000 (2.0). Required: accepted on the first cycle, `res_valid0` exactly LATENCY+1 cycles later with `res_y0`=0x40400000 (3.0), held until `res_ack0`, then cleared.
- **Contention:** both valid on the same cycle after reset; requester 0 has 2.0×3.0, requester 1 has 1.5×2.0. Required: requester 0 accepted first and requester 1 one cycle later. Results 0x40C00000 on `res_y0` and 0x40400000 on `res_y1` arrive one cycle apart.
- **Fairness:** hold both valid and ack each result immediately for 20 ops. Required: grants strictly alternate and no requester gets two consecutive grants while the other is eligible and valid.
- **Result hold:** delay `res_ack1` by 10 cycles while requester 0 keeps issuing. Required: `res_y1` is stable throughout, `req_ready1` stays low, and requester 0 throughput is unaffected.
- **Reset mid-flight:** assert `rst` one cycle after an accept. Required: no `res_valid` ever asserts for that op, and all outputs are 0 after the reset edge.
- **Spurious ack:** pulse `res_ack0` while idle. Required: no state change, and the next request completes normally.
